axi_manager_arbiter: RTL

- Round-robin arbiter that shares the interconnect's satellite-side address/data paths among AXI managers: icache, dcache and debug/DMA.
- Read and write channels are arbitrated independently. Each grant is held for a whole burst, so beats from different managers never interleave.
- Sits inside the AXI interconnect, between the manager-side ports and the satellite address decoder; it drives the manager-select muxes.

---
 rtl/common_types_pkg.sv | 7 +
 rtl/rr_arbiter_ch.sv | 88 ++++++++
 rtl/axi_manager_arbiter.sv | 34 +++
 3 files changed

// File: rtl/common_types_pkg.sv
// common_types_pkg: shared arbiter state encoding and manager index constants
package common_types_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  localparam int MGR_ICACHE = 0;
  localparam int MGR_DCACHE = 1;
  localparam int MGR_DEBUG  = 2;
endpackage

// File: rtl/rr_arbiter_ch.sv
// rr_arbiter_ch: one-channel round-robin arbiter holding each grant for a whole burst
// Optional forced release after TIMEOUT_CYC grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_ch
  import common_types_pkg::*;
#(
  parameter int NUM_MGR     = 3,
  parameter int IDX_W       = $clog2(NUM_MGR),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_MGR-1:0] req,
  input  logic               done,
  output logic [NUM_MGR-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout_err
);
  arb_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, r_ptr, w_ptr_nxt, w_win;
  logic w_any, w_load, w_expire, w_to;
  int w_j;
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = 0;
    for (int i = 0; i < NUM_MGR; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NUM_MGR) w_j = w_j - NUM_MGR;
      if (!w_any && req[IDX_W'(w_j)]) begin
        w_any = 1'b1;
        w_win = IDX_W'(w_j);
      end
    end
  end
  // done re-arbitrates in the same cycle, so back-to-back owners have no bubble
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    w_to        = 1'b0;
    if (w_expire && !done) begin
      w_state_nxt = ARB_IDLE;
      w_to        = 1'b1;
    end else if (r_state == ARB_IDLE || done) begin
      w_state_nxt = w_any ? ARB_GRANT : ARB_IDLE;
      w_load      = w_any;
      w_idx_nxt   = w_any ? w_win : r_idx;
      w_ptr_nxt   = !w_any ? r_ptr : (w_win == IDX_W'(NUM_MGR - 1)) ? '0 : w_win + IDX_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ARB_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end
  assign busy    = r_state == ARB_GRANT;
  assign gnt_idx = r_idx;
  assign gnt     = busy ? NUM_MGR'(1) << r_idx : '0;
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_cnt;
  logic r_to;
  assign w_expire = r_state == ARB_GRANT && r_cnt == CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_cnt <= w_load ? '0 : (r_state == ARB_GRANT) ? r_cnt + CNT_W'(1) : r_cnt;
      r_to  <= w_to;
    end
  end
  assign timeout_err = r_to;
`else
  logic w_unused;
  assign w_unused    = (TIMEOUT_CYC == 0) | w_to | w_load;
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: rtl/axi_manager_arbiter.sv
// axi_manager_arbiter: independent round-robin read/write channel arbiters for icache, dcache, debug
// Define ARB_TIMEOUT_EN to force release of grants held TIMEOUT_CYC cycles.
module axi_manager_arbiter
  import common_types_pkg::*;
#(
  parameter int NUM_MGR     = 3,
  parameter int IDX_W       = $clog2(NUM_MGR),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_MGR-1:0] rd_req,
  input  logic [NUM_MGR-1:0] wr_req,
  input  logic               rd_done,
  input  logic               wr_done,
  output logic [NUM_MGR-1:0] rd_gnt,
  output logic [NUM_MGR-1:0] wr_gnt,
  output logic [IDX_W-1:0]   rd_gnt_idx,
  output logic [IDX_W-1:0]   wr_gnt_idx,
  output logic               rd_busy,
  output logic               wr_busy,
  output logic               timeout_err
);
  logic w_rd_to, w_wr_to;
  rr_arbiter_ch #(.NUM_MGR(NUM_MGR), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rd (
    .clk(clk), .nrst(nrst), .req(rd_req), .done(rd_done),
    .gnt(rd_gnt), .gnt_idx(rd_gnt_idx), .busy(rd_busy), .timeout_err(w_rd_to)
  );
  rr_arbiter_ch #(.NUM_MGR(NUM_MGR), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_wr (
    .clk(clk), .nrst(nrst), .req(wr_req), .done(wr_done),
    .gnt(wr_gnt), .gnt_idx(wr_gnt_idx), .busy(wr_busy), .timeout_err(w_wr_to)
  );
  assign timeout_err = w_rd_to | w_wr_to;
endmodule
